io_reg_slave: RTL and testbench

//  Wishbone-classic I/O responder: device end of the I/O bridge master port.

---
 rtl/io_pkg.sv | 26 ++
 rtl/io_reg_slave.sv | 142 ++++++++++++++
 tb/tb_io_reg_slave.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the I/O register responder.
// Page constant, FSM encoding and byte-lane merge helper.
package io_pkg;

  localparam logic [11:0] IO_PAGE = 12'hFFD;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_reg_slave.sv
// Wishbone-classic I/O register responder with wait states,
// byte-lane writes, read-only status word and access pulses.
module io_reg_slave
  import io_pkg::*;
#(
  parameter logic [31:0] IO_ADDR     = 32'hFFDC0000,
  parameter int          NREGS       = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RST_VAL     = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  output logic                      ack_o,
  input  logic                      we_i,
  input  logic [3:0]                sel_i,
  input  logic [31:0]               adr_i,
  input  logic [31:0]               dat_i,
  output logic [31:0]               dat_o,
  input  logic [31:0]               stat_i,
  output logic [32*(NREGS-1)-1:0]   regs_o,
  output logic [NREGS-1:0]          wr_pulse_o,
  output logic [NREGS-1:0]          rd_pulse_o
);

  localparam int IW  = $clog2(NREGS);
  localparam int AW  = IW + 2;
  localparam int NRW = NREGS - 1;
  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     dat_q;
  logic [3:0]      cnt_q;
  logic [31:0]     rbank [NREGS];
  logic            cs;
  logic            capture;
  logic            commit;
  logic            done;
  logic            unused_adr;

  assign unused_adr = ^adr_i[1:0];

  assign cs = cyc_i & stb_i
            & (adr_i[31:AW] == IO_ADDR[31:AW]);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs) begin
          capture = 1'b1;
          state_d = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = ACK;
        end
      end
      ACK: begin
        // first ACK cycle commits; later cycles wait for strobe release
        if (!ack_o) begin
          commit = 1'b1;
        end else if (!stb_i || !cyc_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o      <= 1'b0;
      dat_o      <= '0;
      wr_pulse_o <= '0;
      rd_pulse_o <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      cnt_q      <= '0;
    end else begin
      wr_pulse_o <= '0;
      rd_pulse_o <= '0;
      if (capture) begin
        idx_q <= adr_i[AW-1:2];
        we_q  <= we_i;
        sel_q <= sel_i;
        dat_q <= dat_i;
        cnt_q <= 4'(WAIT_STATES);
      end else if (state_q == WAIT) begin
        cnt_q <= cyc_i ? cnt_q - 4'd1 : 4'd0;
      end
      if (commit) begin
        ack_o <= 1'b1;
        if (we_q) begin
          wr_pulse_o <= ONE << idx_q;
          dat_o      <= '0;
        end else begin
          rd_pulse_o <= ONE << idx_q;
          dat_o      <= rbank[idx_q];
        end
      end else if (done) begin
        ack_o <= 1'b0;
        dat_o <= '0;
      end
    end
  end

  for (genvar i = 0; i < NRW; i++) begin : g_reg
    logic [31:0] q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q <= RST_VAL;
      end else if (commit && we_q && idx_q == IW'(i)) begin
        q <= lane_merge(q, dat_q, sel_q);
      end
    end
    assign rbank[i]          = q;
    assign regs_o[32*i +: 32] = q;
  end

  assign rbank[NRW] = stat_i;

endmodule

// File: tb/tb_io_reg_slave.sv
// Bench for io_reg_slave: one DUT without and one with wait states.
// Reference model is a plain array of register words.
module tb_io_reg_slave;

  localparam logic [31:0] BASE = 32'hFFDC0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc0, stb0, cyc1, stb1;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, stat;
  logic        ack0, ack1;
  logic [31:0] dat0, dat1;
  logic [7:0]  wp0, wp1, rp0, rp1;
  logic [223:0] regs0, regs1;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [2][8];

  always #5 clk = ~clk;

  io_reg_slave #(.WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .cyc_i(cyc0), .stb_i(stb0), .ack_o(ack0),
    .we_i(we), .sel_i(sel), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat0), .stat_i(stat),
    .regs_o(regs0), .wr_pulse_o(wp0), .rd_pulse_o(rp0)
  );

  io_reg_slave #(.WAIT_STATES(3)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .cyc_i(cyc1), .stb_i(stb1), .ack_o(ack1),
    .we_i(we), .sel_i(sel), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat1), .stat_i(stat),
    .regs_o(regs1), .wr_pulse_o(wp1), .rd_pulse_o(rp1)
  );

  function automatic logic g_ack(int w);
    return w != 0 ? ack1 : ack0;
  endfunction
  function automatic logic [31:0] g_dat(int w);
    return w != 0 ? dat1 : dat0;
  endfunction
  function automatic logic [7:0] g_wp(int w);
    return w != 0 ? wp1 : wp0;
  endfunction
  function automatic logic [7:0] g_rp(int w);
    return w != 0 ? rp1 : rp0;
  endfunction
  function automatic logic [223:0] g_regs(int w);
    return w != 0 ? regs1 : regs0;
  endfunction

  function automatic logic [223:0] mvec(int w);
    logic [223:0] v;
    for (int i = 0; i < 7; i++) v[32*i +: 32] = mdl[w][i];
    return v;
  endfunction

  task automatic drive(input int w, input logic c, input logic s);
    if (w != 0) begin cyc1 = c; stb1 = s; end
    else        begin cyc0 = c; stb0 = s; end
  endtask

  task automatic mdl_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) mdl[w][i] = 32'h0;
  endtask

  task automatic mdl_write(input int w, input int idx,
                           input logic [3:0] s, input logic [31:0] d);
    if (idx == 7) return;
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[w][idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic xfer(input int w, input logic wr, input int idx,
                      input logic [3:0] s, input logic [31:0] d,
                      input int hold, input logic [31:0] st);
    int n;
    logic [31:0] exp;
    logic [7:0] oh;
    @(negedge clk);
    we = wr; sel = s; wdat = d; stat = st;
    adr = BASE | 32'(idx << 2);
    drive(w, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!g_ack(w) && n < 40);
    checks++;
    if (!g_ack(w)) begin
      $display("FAIL ack_timeout w=%0d idx=%0d no ack in %0d cycles",
               w, idx, n);
      errors++;
      drive(w, 1'b0, 1'b0);
      return;
    end
    checks++;
    if (n - 1 != (w != 0 ? 3 : 0) + 1) begin
      $display("FAIL latency w=%0d got %0d edges need %0d",
               w, n - 1, (w != 0 ? 3 : 0) + 1);
      errors++;
    end
    oh = 8'h1 << idx;
    exp = 32'h0;
    if (wr) mdl_write(w, idx, s, d);
    else    exp = (idx == 7) ? st : mdl[w][idx];
    checks++;
    if (g_wp(w) !== (wr ? oh : 8'h0) ||
        g_rp(w) !== (wr ? 8'h0 : oh)) begin
      $display("FAIL pulse w=%0d wr=%b idx=%0d got wp=%h rp=%h",
               w, wr, idx, g_wp(w), g_rp(w));
      errors++;
    end
    if (!wr) begin
      checks++;
      if (g_dat(w) !== exp) begin
        $display("FAIL rdata w=%0d idx=%0d got %h need %h",
                 w, idx, g_dat(w), exp);
        errors++;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (g_ack(w) !== 1'b1 || g_wp(w) !== 8'h0 ||
          g_rp(w) !== 8'h0 || (!wr && g_dat(w) !== exp)) begin
        $display("FAIL hold w=%0d cyc=%0d ack=%b wp=%h rp=%h dat=%h",
                 w, h, g_ack(w), g_wp(w), g_rp(w), g_dat(w));
        errors++;
      end
    end
    drive(w, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (g_ack(w) !== 1'b0 || g_dat(w) !== 32'h0 ||
        g_wp(w) !== 8'h0 || g_rp(w) !== 8'h0) begin
      $display("FAIL release w=%0d ack=%b dat=%h wp=%h rp=%h",
               w, g_ack(w), g_dat(w), g_wp(w), g_rp(w));
      errors++;
    end
    checks++;
    if (g_regs(w) !== mvec(w)) begin
      $display("FAIL regs w=%0d got %h need %h", w, g_regs(w), mvec(w));
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc0 = 0; stb0 = 0; cyc1 = 0; stb1 = 0;
    we = 0; sel = 0; adr = 0; wdat = 0; stat = 0;
    mdl_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (g_ack(w) !== 1'b0 || g_dat(w) !== 32'h0 || g_wp(w) !== 8'h0 ||
          g_rp(w) !== 8'h0 || g_regs(w) !== mvec(w)) begin
        $display("FAIL reset w=%0d ack=%b dat=%h wp=%h rp=%h regs=%h",
                 w, g_ack(w), g_dat(w), g_wp(w), g_rp(w), g_regs(w));
        errors++;
      end
    end
  endtask

  task automatic test_write_full();
    xfer(0, 1'b1, 2, 4'hF, 32'hDEADBEEF, 0, 32'h0);
  endtask

  task automatic test_byte_lane();
    xfer(0, 1'b1, 2, 4'b0010, 32'h11223344, 0, 32'h0);
    checks++;
    if (regs0[64 +: 32] !== 32'hDEAD33EF) begin
      $display("FAIL byte_lane got %h need DEAD33EF", regs0[64 +: 32]);
      errors++;
    end
  endtask

  task automatic test_status_read();
    xfer(1, 1'b0, 7, 4'hF, 32'h0, 0, 32'hA5A5_0001);
  endtask

  task automatic test_hold();
    xfer(0, 1'b0, 2, 4'h1, 32'h0, 5, 32'h0);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    we = 1'b1; sel = 4'hF; wdat = 32'hCAFE0003;
    adr = BASE | 32'(3 << 2);
    drive(0, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack0 && n < 40);
    checks++;
    if (!ack0) begin
      $display("FAIL b2b_timeout no ack in %0d cycles", n);
      errors++;
    end
    mdl_write(0, 3, 4'hF, 32'hCAFE0003);
    adr = BASE | 32'(4 << 2);
    wdat = 32'hBAD00004;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b1 || wp0 !== 8'h0) begin
        $display("FAIL b2b_overlap cyc=%0d ack=%b wp=%h", h, ack0, wp0);
        errors++;
      end
    end
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0 || regs0 !== mvec(0)) begin
      $display("FAIL b2b_state ack=%b regs=%h need %h",
               ack0, regs0, mvec(0));
      errors++;
    end
    xfer(0, 1'b0, 4, 4'hF, 32'h0, 0, 32'h0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    we = 1'b1; sel = 4'hF; wdat = 32'h0BAD0BAD;
    adr = BASE | 32'(1 << 2);
    drive(1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    drive(1, 1'b0, 1'b1);
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      checks++;
      if (ack1 !== 1'b0 || wp1 !== 8'h0 || rp1 !== 8'h0) begin
        $display("FAIL abort cyc=%0d ack=%b wp=%h rp=%h",
                 h, ack1, wp1, rp1);
        errors++;
      end
    end
    drive(1, 1'b0, 1'b0);
    checks++;
    if (regs1 !== mvec(1)) begin
      $display("FAIL abort_regs got %h need %h", regs1, mvec(1));
      errors++;
    end
    xfer(1, 1'b0, 1, 4'hF, 32'h0, 0, 32'h0);
  endtask

  task automatic test_out_of_window();
    @(negedge clk);
    we = 1'b1; sel = 4'hF; wdat = 32'h12345678;
    adr = 32'hFFDB0000;
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b1);
    for (int h = 0; h < 8; h++) begin
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 ||
          wp0 !== 8'h0 || wp1 !== 8'h0) begin
        $display("FAIL out_of_window cyc=%0d ack=%b%b wp=%h/%h",
                 h, ack0, ack1, wp0, wp1);
        errors++;
      end
    end
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
  endtask

  task automatic test_sel_zero();
    xfer(0, 1'b1, 1, 4'h0, 32'hFFFFFFFF, 1, 32'h0);
    xfer(1, 1'b1, 5, 4'h0, 32'hFFFFFFFF, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           $urandom, int'($urandom_range(0, 2)), $urandom);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    we = 1'b1; sel = 4'hF; wdat = 32'h77777777;
    adr = BASE | 32'(6 << 2);
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack0 && n < 40);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      $display("FAIL rst_mid_setup ack0=%b ack1=%b", ack0, ack1);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    mdl_reset();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (g_ack(w) !== 1'b0 || g_regs(w) !== mvec(w) ||
          g_wp(w) !== 8'h0) begin
        $display("FAIL rst_mid w=%0d ack=%b wp=%h regs=%h",
                 w, g_ack(w), g_wp(w), g_regs(w));
        errors++;
      end
    end
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b1, 0, 4'hF, 32'h13572468, 0, 32'h0);
    xfer(1, 1'b0, 0, 4'hF, 32'h0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_byte_lane();
    test_status_read();
    test_hold();
    test_back_to_back();
    test_abort();
    test_out_of_window();
    test_sel_zero();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
